mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  Memory-side bus sequencer directly downstream of the CPU datapath. Accepts one fetch/load/store request at a time.
//  Drives readM/writeM/address and the shared bidirectional data bus. Completes each access on the memory's
//  inputReady/ackOutput handshake and returns read data or write completion to the datapath as a one-cycle response.
// PARAMETERS
//  WORD_SIZE        16   data/address width; default taken from `WORD_SIZE in opcodes.v
//  TIMEOUT_CYCLES   64   cycles spent in READ/WRITE before abort; used only when MEM_TIMEOUT_EN is defined
// PORTS
//  clk          in     1          system clock, rising edge
//  reset_n      in     1          asynchronous, active-low reset
//  req_valid    in     1          datapath requests an access; sampled only while req_ready=1
//  req_write    in     1          1 = store, 0 = fetch/load
//  req_addr     in     WORD_SIZE  access address
//  req_wdata    in     WORD_SIZE  store data
//  req_ready    out    1          high only in IDLE
//  resp_valid   out    1          one-cycle pulse: read data valid, or write done
//  resp_rdata   out    WORD_SIZE  data read; holds value until the next read completes
//  resp_err     out    1          valid with resp_valid; 1 = access timed out
//  readM        out    1          memory read strobe
//  writeM       out    1          memory write strobe
//  address      out    WORD_SIZE  memory address
//  data         inout  WORD_SIZE  shared bus; driven only in WRITE, else high-Z
//  inputReady   in     1          memory has read data on data
//  ackOutput    in     1          memory has accepted write data
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE. readM=0, writeM=0, address=0, data=Z, resp_valid=0,
//    resp_rdata=0, resp_err=0, timeout count=0.
//  - Moore FSM; all outputs are decoded from registered state and registers:
//    IDLE:  req_ready=1. On req_valid, latch addr/wdata/write; go to WRITE if req_write, else READ.
//    READ:  readM=1, address=addr_q, data=Z. When inputReady=1, latch data into resp_rdata; go to RESP.
//    WRITE: writeM=1, address=addr_q, data=wdata_q. When ackOutput=1, go to RESP.
//    RESP:  resp_valid=1 for exactly one cycle; then go to IDLE.
//  - Minimum latency: accept at edge N; strobe high in cycle N+1; if the handshake is sampled at edge N+1,
//    resp_valid is high in cycle N+2. New request accepted at edge N+3 at the earliest.
//  - readM and writeM are never high together. data is driven only when writeM=1.
//  - address holds addr_q after the access completes. It returns to 0 only on reset.
//  - Ignored inputs:
//    req_valid outside IDLE; inputReady in any state except READ; ackOutput in any state except WRITE.
//    Stray handshakes cause no state change.
//  - Handshake held high across accesses: it is sampled only in the matching state, so the next access
//    completes one cycle after its strobe rises.
//  - Reset mid-access: strobes drop and the bus releases immediately; no response is generated;
//    the pending request is discarded.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//    - A counter runs while in READ/WRITE and clears on entry.
//    - If it reaches TIMEOUT_CYCLES-1 with no handshake: go to RESP with resp_err=1.
//      A read also sets resp_rdata=all-ones.
//    - A handshake in the same cycle as the limit wins (resp_err=0).
//  MEM_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; resp_err tied 0.
// STRUCTURE
//  - WORD_SIZE comes from opcodes.v.
//  - 2-bit state encodings (`MBC_IDLE=0, `MBC_READ=1, `MBC_WRITE=2, `MBC_RESP=3) go in shared include mem_bus_defs.v.
//  - One sub-module: mem_timeout_counter (clear, enable, limit-reached flag). It is instantiated only
//    under MEM_TIMEOUT_EN.
// TESTING
//  1. Read: req addr=16'h0010, read. inputReady=1 two cycles after readM rises, data=16'h6A05
//     -> readM high exactly 3 cycles, address=16'h0010, resp_valid one pulse, resp_rdata=16'h6A05, resp_err=0.
//  2. Write: req addr=16'h0020, wdata=16'hBEEF. ackOutput after 1 cycle
//     -> data=16'hBEEF while writeM=1, data=Z before and after, resp_valid pulse, readM stays 0.
//  3. Stray handshakes: ackOutput=1 during READ and inputReady=1 during IDLE -> no state change,
//     no resp_valid; req_valid pulsed during READ is not accepted.
//  4. Reset mid-access: reset_n=0 two cycles into READ
//     -> readM=0, data=Z, address=0 immediately; no resp_valid after release; IDLE with req_ready=1.
//  5. Back-to-back with inputReady stuck high: two reads -> each completes at minimum latency;
//     resp_valid pulses 3 cycles apart.
//  6. MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8: read, no inputReady -> resp_valid after 8 READ cycles,
//     resp_err=1, resp_rdata=16'hFFFF.
//     Without macro: still waiting after 100 cycles.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg
//   Shared definitions for the memory bus sequencer: default word size,
//   the 2-bit sequencer state encoding and a small state helper.
//   No ports (package).
package mem_bus_ctrl_pkg;

    localparam int WORD_SIZE_DEF = 16;

    // Fixed encodings: IDLE=0, READ=1, WRITE=2, RESP=3.
    typedef enum logic [1:0] {
        MBC_IDLE  = 2'd0,
        MBC_READ  = 2'd1,
        MBC_WRITE = 2'd2,
        MBC_RESP  = 2'd3
    } mbc_state_e;

    // True while a memory access is in flight (a strobe is high).
    function automatic logic is_access(input mbc_state_e s);
        return (s == MBC_READ) || (s == MBC_WRITE);
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_timeout_counter.sv
// mem_timeout_counter
//   Counts cycles spent in an access. Cleared while no access is in flight,
//   so it reads 0 in the first cycle of every access.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   clear_i  in   synchronous clear (takes priority over en_i)
//   en_i     in   count enable
//   hit_o    out  count has reached LIMIT-1
module mem_timeout_counter #(
    parameter int LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic hit_o
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign hit_o = (cnt_q == CW'(LIMIT - 1));

    // Saturates at the limit; the sequencer leaves the access on hit anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !hit_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Memory-side bus sequencer. Takes one fetch/load/store request at a time
//   from the datapath, runs it on readM/writeM/address/data and returns a
//   one-cycle response (read data or write done).
//   Optional feature macro: MEM_TIMEOUT_EN -- aborts an access after
//   TIMEOUT_CYCLES cycles without a handshake (resp_err=1, read data all-ones).
// Ports:
//   clk, reset_n                 clock / async active-low reset
//   req_valid/req_write/req_addr/req_wdata/req_ready   request side
//   resp_valid/resp_rdata/resp_err                      response side
//   readM/writeM/address/data/inputReady/ackOutput      memory side
//   dbg_state_o                  current sequencer state
// Handshake: a request transfers on a rising edge where req_valid=1 and
//   req_ready=1; req_ready is high only in IDLE. resp_valid is a single-cycle
//   pulse with no back-pressure. inputReady is honoured only in READ,
//   ackOutput only in WRITE; everywhere else they are ignored.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int WORD_SIZE      = WORD_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output mbc_state_e           dbg_state_o
);

    mbc_state_e           state_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 err_q;
    logic                 timeout_hit;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clear_i (!is_access(state_q)),
        .en_i    (is_access(state_q)),
        .hit_o   (timeout_hit)
    );
`else
    // No abort path: the sequencer waits for the handshake indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    // Moore outputs: everything below is decoded from registered state.
    assign req_ready   = (state_q == MBC_IDLE);
    assign readM       = (state_q == MBC_READ);
    assign writeM      = (state_q == MBC_WRITE);
    assign resp_valid  = (state_q == MBC_RESP);
    assign resp_err    = resp_valid & err_q;
    assign resp_rdata  = rdata_q;
    assign address     = addr_q;
    assign dbg_state_o = state_q;
    // Bus is driven only while writeM is high.
    assign data        = writeM ? wdata_q : {WORD_SIZE{1'bz}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MBC_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                MBC_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state_q <= req_write ? MBC_WRITE : MBC_READ;
                    end
                end
                MBC_READ: begin
                    // A handshake on the limit cycle takes precedence.
                    if (inputReady) begin
                        rdata_q <= data;
                        err_q   <= 1'b0;
                        state_q <= MBC_RESP;
                    end else if (timeout_hit) begin
                        rdata_q <= '1;
                        err_q   <= 1'b1;
                        state_q <= MBC_RESP;
                    end
                end
                MBC_WRITE: begin
                    if (ackOutput) begin
                        err_q   <= 1'b0;
                        state_q <= MBC_RESP;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= MBC_RESP;
                    end
                end
                default: begin
                    state_q <= MBC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl
//   Directed bench for mem_bus_ctrl: a cycle-by-cycle vector table covering
//   read, write and stray handshakes, plus hand-written sequences for reset
//   mid-access, back-to-back reads and the timeout / no-timeout behaviour.
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid, req_write;
    logic [W-1:0] req_addr, req_wdata;
    logic         req_ready, resp_valid, resp_err;
    logic [W-1:0] resp_rdata, address;
    logic         readM, writeM, inputReady, ackOutput;
    wire  [W-1:0] data;
    mbc_state_e   dbg_state;

    logic [W-1:0] mem_drv;

    int checks = 0;
    int errors = 0;

    // Memory model drives the bus only while the sequencer is reading.
    assign data = (inputReady && readM) ? mem_drv : {W{1'bz}};

    mem_bus_ctrl #(
        .WORD_SIZE      (W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .readM       (readM),
        .writeM      (writeM),
        .address     (address),
        .data        (data),
        .inputReady  (inputReady),
        .ackOutput   (ackOutput),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time limit)");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic bus_released();
        return (data === {W{1'bz}}) || (data === {W{1'b0}});
    endfunction

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        inputReady = 1'b0;
        ackOutput  = 1'b0;
        mem_drv    = '0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rv, rw;
        logic [W-1:0] a, wd;
        logic         ir, ack;
        logic [W-1:0] md;
        logic [1:0]   st;
        logic         rdm, wrm, rsv, rdy;
        logic [W-1:0] adr, rd, db;
    } vec_t;

    function automatic vec_t mk(
        input logic rv, input logic rw, input logic [W-1:0] a, input logic [W-1:0] wd,
        input logic ir, input logic ack, input logic [W-1:0] md,
        input logic [1:0] st, input logic rdm, input logic wrm, input logic rsv, input logic rdy,
        input logic [W-1:0] adr, input logic [W-1:0] rd, input logic [W-1:0] db);
        vec_t v;
        v.rv = rv; v.rw = rw; v.a = a; v.wd = wd; v.ir = ir; v.ack = ack; v.md = md;
        v.st = st; v.rdm = rdm; v.wrm = wrm; v.rsv = rsv; v.rdy = rdy;
        v.adr = adr; v.rd = rd; v.db = db;
        return v;
    endfunction

    vec_t vecs[16];

    int           rd_cycles;
    int           npulse;
    int           pcyc[2];
    logic [W-1:0] prd[2];
    logic         seen_resp;

    initial begin
        //           rv rw addr     wdata    ir ack mem      st readM writeM rv  rdy address  rdata    bus
        vecs[0]  = mk(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000);
        vecs[1]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000);
        vecs[2]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000);
        vecs[3]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h6A05, 3, 0, 0, 1, 0, 16'h0010, 16'h6A05, 16'h0000);
        vecs[4]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0010, 16'h6A05, 16'h0000);
        vecs[5]  = mk(1, 1, 16'h0020, 16'hBEEF, 0, 0, 16'h0000, 2, 0, 1, 0, 0, 16'h0020, 16'h6A05, 16'hBEEF);
        vecs[6]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2, 0, 1, 0, 0, 16'h0020, 16'h6A05, 16'hBEEF);
        vecs[7]  = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 3, 0, 0, 1, 0, 16'h0020, 16'h6A05, 16'h0000);
        vecs[8]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0020, 16'h6A05, 16'h0000);
        vecs[9]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'hDEAD, 0, 0, 0, 0, 1, 16'h0020, 16'h6A05, 16'h0000);
        vecs[10] = mk(1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0030, 16'h6A05, 16'h0000);
        vecs[11] = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 1, 0, 0, 0, 16'h0030, 16'h6A05, 16'h0000);
        vecs[12] = mk(1, 1, 16'h0040, 16'h1234, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 16'h0030, 16'h6A05, 16'h0000);
        vecs[13] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0BAD, 3, 0, 0, 1, 0, 16'h0030, 16'h0BAD, 16'h0000);
        vecs[14] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0030, 16'h0BAD, 16'h0000);
        vecs[15] = mk(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 0, 0, 0, 1, 16'h0030, 16'h0BAD, 16'h0000);

        // ---------------- reset ----------------
        reset_n = 1'b0;
        idle_inputs();
        #12;
        chk("rst_state",      32'(dbg_state),  32'(MBC_IDLE));
        chk("rst_readM",      32'(readM),      32'd0);
        chk("rst_writeM",     32'(writeM),     32'd0);
        chk("rst_address",    32'(address),    32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_resp_err",   32'(resp_err),   32'd0);
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_bus_z",      32'(bus_released()), 32'd1);
        tick();
        reset_n = 1'b1;

        // ---------------- table: read, write, stray handshakes ----------------
        for (int i = 0; i < 16; i++) begin
            req_valid  = vecs[i].rv;
            req_write  = vecs[i].rw;
            req_addr   = vecs[i].a;
            req_wdata  = vecs[i].wd;
            inputReady = vecs[i].ir;
            ackOutput  = vecs[i].ack;
            mem_drv    = vecs[i].md;
            tick();
            chk($sformatf("v%0d_state", i),      32'(dbg_state),  32'(vecs[i].st));
            chk($sformatf("v%0d_readM", i),      32'(readM),      32'(vecs[i].rdm));
            chk($sformatf("v%0d_writeM", i),     32'(writeM),     32'(vecs[i].wrm));
            chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(vecs[i].rsv));
            chk($sformatf("v%0d_req_ready", i),  32'(req_ready),  32'(vecs[i].rdy));
            chk($sformatf("v%0d_address", i),    32'(address),    32'(vecs[i].adr));
            chk($sformatf("v%0d_resp_rdata", i), 32'(resp_rdata), 32'(vecs[i].rd));
            chk($sformatf("v%0d_resp_err", i),   32'(resp_err),   32'd0);
            if (vecs[i].wrm)
                chk($sformatf("v%0d_bus_data", i), 32'(data), 32'(vecs[i].db));
            else
                chk($sformatf("v%0d_bus_z", i), 32'(bus_released()), 32'd1);
        end
        idle_inputs();

        // ---------------- reset two cycles into a read ----------------
        req_valid = 1'b1;
        req_addr  = 16'h0050;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_pre_readM", 32'(readM), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_readM",      32'(readM),      32'd0);
        chk("mid_address",    32'(address),    32'd0);
        chk("mid_bus_z",      32'(bus_released()), 32'd1);
        chk("mid_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        seen_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid) seen_resp = 1'b1;
        end
        chk("mid_no_resp",   32'(seen_resp), 32'd0);
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        chk("mid_state",     32'(dbg_state), 32'(MBC_IDLE));

        // ---------------- back-to-back reads, inputReady stuck high ----------------
        mem_drv    = 16'h1111;
        inputReady = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 16'h0060;
        npulse     = 0;
        pcyc[0] = -1; pcyc[1] = -1;
        prd[0]  = '0; prd[1]  = '0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (resp_valid && npulse < 2) begin
                pcyc[npulse] = i;
                prd[npulse]  = resp_rdata;
                npulse++;
                if (npulse == 1) begin
                    mem_drv  = 16'h2222;
                    req_addr = 16'h0062;
                end
            end
        end
        idle_inputs();
        chk("b2b_pulses",  32'(npulse),  32'd2);
        chk("b2b_first",   32'(pcyc[0]), 32'd2);
        chk("b2b_second",  32'(pcyc[1]), 32'd5);
        chk("b2b_rdata0",  32'(prd[0]),  32'h1111);
        chk("b2b_rdata1",  32'(prd[1]),  32'h2222);
        tick();
        chk("b2b_idle",    32'(dbg_state), 32'(MBC_IDLE));

        // ---------------- read with no inputReady ----------------
        req_valid = 1'b1;
        req_addr  = 16'h0070;
        tick();
        req_valid = 1'b0;
        rd_cycles = readM ? 1 : 0;
        seen_resp = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 20 && !seen_resp; i++) begin
            tick();
            if (resp_valid) seen_resp = 1'b1;
            else if (readM) rd_cycles++;
        end
        chk("tmo_resp_seen",  32'(seen_resp),  32'd1);
        chk("tmo_read_cycles", 32'(rd_cycles), 32'd8);
        chk("tmo_resp_err",   32'(resp_err),   32'd1);
        chk("tmo_resp_rdata", 32'(resp_rdata), 32'hFFFF);
        tick();
        chk("tmo_idle",       32'(dbg_state),  32'(MBC_IDLE));
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (resp_valid) seen_resp = 1'b1;
        end
        chk("wait_no_resp", 32'(seen_resp), 32'd0);
        chk("wait_readM",   32'(readM),     32'd1);
        chk("wait_state",   32'(dbg_state), 32'(MBC_READ));
        mem_drv    = 16'h7777;
        inputReady = 1'b1;
        tick();
        inputReady = 1'b0;
        chk("wait_resp_valid", 32'(resp_valid), 32'd1);
        chk("wait_resp_rdata", 32'(resp_rdata), 32'h7777);
        chk("wait_resp_err",   32'(resp_err),   32'd0);
        tick();
        chk("wait_idle",       32'(dbg_state),  32'(MBC_IDLE));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
